// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and state encodings for the i2c arbiter slice
//
// Holds the master's idle state code, the field widths and the arbiter FSM
// state encoding. No ports.
package i2c_pkg;

    localparam logic [2:0] I2C_ST_IDLE = 3'd0;
    localparam int         I2C_ADDR_W  = 7;
    localparam int         I2C_DATA_W  = 8;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_LAUNCH    = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_IDLE = 3'd3,
        ARB_DONE      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// rtl/i2c_bus_arbiter_if.sv - requester and i2c_master signal bundle for the arbiter
//
// Signals:
//   requester side : req, req_addr, req_rw, req_wdata (in to arbiter)
//                    gnt, done, rdata, ack_error, timeout (out of arbiter)
//   master side    : m_start, m_addr, m_rw, m_data_in (out of arbiter)
//                    m_data_out, m_ack_error, m_state (in to arbiter)
// Modports: master = the arbiter, slave = clients plus i2c_master.
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import i2c_pkg::*;

    logic [NUM_REQ-1:0]            req;
    logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_rw;
    logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [I2C_DATA_W-1:0]         rdata;
    logic                          ack_error;
    logic                          timeout;
    logic                          m_start;
    logic [I2C_ADDR_W-1:0]         m_addr;
    logic                          m_rw;
    logic [I2C_DATA_W-1:0]         m_data_in;
    logic [I2C_DATA_W-1:0]         m_data_out;
    logic                          m_ack_error;
    logic [2:0]                    m_state;

    modport master (
        input  req, req_addr, req_rw, req_wdata,
        input  m_data_out, m_ack_error, m_state,
        output gnt, done, rdata, ack_error, timeout,
        output m_start, m_addr, m_rw, m_data_in
    );

    modport slave (
        output req, req_addr, req_rw, req_wdata,
        output m_data_out, m_ack_error, m_state,
        input  gnt, done, rdata, ack_error, timeout,
        input  m_start, m_addr, m_rw, m_data_in
    );

endinterface

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin winner selection
//
// Ports:
//   i_req    : per-requester request vector
//   i_ptr    : index where the search starts (wraps modulo NUM_REQ)
//   o_onehot : one-hot winner
//   o_idx    : winner index
//   o_valid  : at least one request present
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_j      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[w_j]) begin
                o_valid       = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin sharing of one i2c_master among NUM_REQ requesters
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : i2c_bus_arbiter_if.master (requests/grants/results and master control)
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort transfers that stay
// in WAIT_BUSY/WAIT_IDLE for TIMEOUT_CYCLES cycles.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_bus_arbiter_if.master     bus
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_win_idx;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_done;
    logic [I2C_DATA_W-1:0] r_rdata;
    logic                  r_ack_error;
    logic                  r_timeout;
    logic                  r_start;
    logic [I2C_ADDR_W-1:0] r_addr;
    logic                  r_rw;
    logic [I2C_DATA_W-1:0] r_wdata;

    logic [NUM_REQ-1:0]    w_pick_onehot;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    logic                  w_wd_expired;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_in_wait;

    assign w_in_wait    = (r_state == ARB_WAIT_BUSY) || (r_state == ARB_WAIT_IDLE);
    assign w_wd_expired = w_in_wait && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset || !w_in_wait) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wd_expired = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:      if (w_pick_valid) w_state_next = ARB_LAUNCH;
            ARB_LAUNCH:    w_state_next = ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: begin
                if (w_wd_expired)                  w_state_next = ARB_DONE;
                else if (bus.m_state != I2C_ST_IDLE) w_state_next = ARB_WAIT_IDLE;
            end
            ARB_WAIT_IDLE: begin
                if (w_wd_expired || bus.m_state == I2C_ST_IDLE) w_state_next = ARB_DONE;
            end
            ARB_DONE:      w_state_next = ARB_IDLE;
            default:       w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_win_idx   <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_ack_error <= 1'b0;
            r_timeout   <= 1'b0;
            r_start     <= 1'b0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_state_next;
            r_start <= 1'b0;
            r_done  <= '0;
            case (r_state)
                ARB_IDLE: begin
                    // Fields are latched once here so later req_* changes are ignored.
                    if (w_pick_valid) begin
                        r_gnt     <= w_pick_onehot;
                        r_win_idx <= w_pick_idx;
                        r_addr    <= bus.req_addr[int'(w_pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                        r_rw      <= bus.req_rw[w_pick_idx];
                        r_wdata   <= bus.req_wdata[int'(w_pick_idx)*I2C_DATA_W +: I2C_DATA_W];
                        r_start   <= 1'b1;
                    end
                end
                ARB_WAIT_BUSY, ARB_WAIT_IDLE: begin
                    // Entering DONE: results become visible together with done.
                    // A watchdog abort keeps the previous rdata.
                    if (w_state_next == ARB_DONE) begin
                        r_done    <= r_gnt;
                        r_timeout <= w_wd_expired;
                        if (w_wd_expired) begin
                            r_ack_error <= 1'b1;
                        end else begin
                            r_rdata     <= bus.m_data_out;
                            r_ack_error <= bus.m_ack_error;
                        end
                    end
                end
                ARB_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= (r_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.ack_error = r_ack_error;
    assign bus.timeout   = r_timeout;
    assign bus.m_start   = r_start;
    assign bus.m_addr    = r_addr;
    assign bus.m_rw      = r_rw;
    assign bus.m_data_in = r_wdata;

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin scheduler that shares one `i2c_master` between `NUM_REQ` requesters. Each requester posts a single-byte transaction (7-bit address, R/W, write byte). The arbiter grants one requester at a time, drives the master's `start`/`addr`/`rw`/`data_in`, and tracks the master's `state` output until the transfer completes. It then returns read data and ack status to the winner. It sits between client logic and `i2c_master`; SDA/SCL stay inside the master.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in clk cycles (used only with `I2C_ARB_TIMEOUT_EN`).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester transaction request, level.
- `req_addr`  in  7*NUM_REQ  packed slave addresses; slice i belongs to requester i.
- `req_rw`  in  NUM_REQ  1 = read, 0 = write.
- `req_wdata`  in  8*NUM_REQ  packed write bytes.
- `gnt`  out  NUM_REQ  one-hot grant, high for the whole transaction.
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rdata`  out  8  read byte; valid during `done`, held until the next `done`.
- `ack_error`  out  1  NACK or timeout flag for the last transaction; valid with `done`.
- `timeout`  out  1  last transaction was aborted by the watchdog.
- `m_start`  out  1  start pulse to the master.
- `m_addr`  out  7, `m_rw`  out  1, `m_data_in`  out  8: transaction fields for the master.
- `m_data_out`  in  8, `m_ack_error`  in  1, `m_state`  in  3: master results and FSM state.

## Operation
- FSM states and transitions:
  - IDLE: when `req` != 0, select a winner, set `gnt`, latch its addr/rw/wdata into the `m_*` registers, go to LAUNCH.
  - LAUNCH: `m_start`=1 for exactly this one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait until `m_state` != `I2C_ST_IDLE`, then go to WAIT_IDLE.
  - WAIT_IDLE: wait until `m_state` == `I2C_ST_IDLE`, then go to DONE.
  - DONE: pulse `done[winner]`, drive captured `rdata`/`ack_error`, clear `gnt`, advance the pointer, return to IDLE.
- Round-robin pointer:
  - Reset value is 0.
  - The search starts at pointer and wraps modulo NUM_REQ.
  - After DONE, pointer = winner+1, wrapping from NUM_REQ-1 to 0.
- `rdata` and `ack_error` are captured from `m_data_out` and `m_ack_error` on the WAIT_IDLE→DONE edge. `rdata` is captured on writes too.
- The `m_*` fields are stable from LAUNCH through DONE. Changes on `req_*` while granted are ignored.
- Requester rule: hold `req` and fields until `done`, and drop `req` in the cycle after `done`. The arbiter always spends one IDLE cycle after DONE, so a `req` still high in that cycle is treated as a new request.
- Dropping `req` mid-transaction does not abort; the transaction completes and `done` still pulses.
- Reset mid-operation: next edge forces IDLE, pointer 0, and all outputs 0. No `done` is issued for the killed transaction.
- Reset values: `gnt`, `done`, `rdata`, `ack_error`, `timeout`, `m_start`, `m_addr`, `m_rw`, `m_data_in` are all 0.

## Timing
- Cycle-level sequence, with `req` first sampled high in IDLE at edge k:
  - edge k+1: `gnt` and `m_*` valid, `m_start`=1 for one cycle.
  - edge k+2: `m_start`=0.
  - `done` rises one edge after `m_state` is first seen back at IDLE.
- Arbiter overhead is 3 cycles beyond master busy time. Back-to-back grants are separated by ≥1 IDLE cycle.
- All outputs are registered; there are no combinational paths from `req` to `gnt` or `m_*`.

## Configuration
- `I2C_ARB_TIMEOUT_EN`, when defined:
  - A counter runs during WAIT_BUSY and WAIT_IDLE and clears in IDLE.
  - On reaching TIMEOUT_CYCLES-1, the FSM goes to DONE with `timeout`=1 and `ack_error`=1.
  - `rdata` holds its previous value and the pointer advances normally.
- When undefined: no counter is built, `timeout` is tied 0, and the FSM waits indefinitely.

## Structure
- Shared package `i2c_pkg` holds:
  - `I2C_ST_IDLE` = 3'd0, the master's idle encoding.
  - `I2C_ADDR_W` = 7 and `I2C_DATA_W` = 8.
  - Arbiter state encodings: IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, DONE.
- One sub-module, `i2c_rr_pick`: combinational, taking `req` and pointer and returning a one-hot winner plus its index. It is instantiated once.

## Test plan
- Single write: reset low 2 cycles; req[1]=1, addr 7'h55, rw 0, wdata 8'h2B → `gnt`=4'b0010, one `m_start` pulse, `m_addr`=7'h55, `m_data_in`=8'h2B, then `done[1]` pulse with `ack_error`=0.
- Read: req[2] with rw 1 and slave data 8'h93 → `done[2]` with `rdata`=8'h93, and `rdata` holds after `done`.
- Contention: req=4'b1111 held, each requester dropping `req` after its `done` → grant order 0,1,2,3, with exactly one `m_start` per grant and ≥1 IDLE cycle between grants.
- Fairness wrap: after req[3] completes, assert req[0] and req[3] together → req[0] is granted first.
- NACK: address with no matching slave → `done` with `ack_error`=1 and `timeout`=0.
- Reset mid-transaction in WAIT_IDLE → next edge all outputs 0; later req[0] → grant 0.
- With `I2C_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, hold `m_state` non-idle → `done` 16 cycles after LAUNCH with `timeout`=1 and `ack_error`=1.
